// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller: request sizes,
// FSM states and byte/half lane selection for either endianness.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Physical byte position within the 32-bit word for a byte address offset.
    function automatic logic [1:0] byte_lane(input logic [1:0] addr_lo, input logic big_endian);
        return big_endian ? ~addr_lo : addr_lo;
    endfunction

    // Physical half position (0 = bits 15:0, 1 = bits 31:16) for addr[1].
    function automatic logic half_lane(input logic addr_1, input logic big_endian);
        return big_endian ? ~addr_1 : addr_1;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline request/response handshake plus the single-port memory bus.
interface dmem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_R_W;
    logic [31:0] mem_Addr;
    logic [31:0] mem_Data_in;
    logic [31:0] mem_Data_out;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_Data_out,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_R_W, mem_Addr, mem_Data_in
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_Data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_R_W, mem_Addr, mem_Data_in
    );
endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extracts and extends load data, and merges
// sub-word store data into a read word for read-modify-write.
module dmem_lane_unit
    import dmem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    function automatic logic [31:0] extract_ext(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [1:0] size, input logic uns);
        logic [1:0]  bl;
        logic        hl;
        logic [7:0]  b;
        logic [15:0] h;
        bl = byte_lane(lo, BIG_ENDIAN);
        hl = half_lane(lo[1], BIG_ENDIAN);
        b  = word[{bl, 3'b000} +: 8];
        h  = word[{hl, 4'b0000} +: 16];
        case (size)
            SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] lo,
                                          input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] m;
        logic [1:0]  bl;
        logic        hl;
        bl = byte_lane(lo, BIG_ENDIAN);
        hl = half_lane(lo[1], BIG_ENDIAN);
        m  = word;
        case (size)
            SZ_BYTE: m[{bl, 3'b000} +: 8]   = wdata[7:0];
            SZ_HALF: m[{hl, 4'b0000} +: 16] = wdata[15:0];
            default: m = wdata;
        endcase
        return m;
    endfunction

    always_comb begin
        rdata_o  = extract_ext(word_i, addr_lo_i, size_i, unsigned_i);
        merged_o = merge(word_i, addr_lo_i, size_i, wdata_i);
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Byte-addressed load/store initiator for a word-addressed single-port memory;
// sub-word stores are read-modify-write, loads return extended lane data.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input logic           clk,
    input logic           rst,
    dmem_access_ctrl_if.slave bus
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        req_err;
    logic [31:0] lane_rdata;
    logic [31:0] lane_merged;

    dmem_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .word_i    (bus.mem_Data_out),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .wdata_i   (wdata_q),
        .rdata_o   (lane_rdata),
        .merged_o  (lane_merged)
    );

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    always_comb begin
        req_err = (bus.req_size == SZ_ILL)
               || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
               || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
               || ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err)                    state_d = ST_RESP;
                    else if (!bus.req_we)           state_d = ST_LOAD;
                    else if (bus.req_size == SZ_WORD) state_d = ST_STORE;
                    else                            state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                rdata_d = lane_rdata;
                state_d = ST_RESP;
            end
            ST_STORE:  state_d = ST_RESP;
            // The merged word replaces the store data so mem_Data_in stays a plain register.
            ST_RMW_RD: begin
                wdata_d = lane_merged;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.mem_R_W     = (state_q == ST_STORE) || (state_q == ST_RMW_WR);
    assign bus.mem_Addr    = {2'b00, addr_q[31:2]};
    assign bus.mem_Data_in = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench: directed vector table, back-to-back and reset corner
// cases, then random traffic against a byte-addressed reference memory.
module tb_dmem_access_ctrl;
    localparam int MW = 1024;
    localparam bit BE = 1'b0;
    localparam int RB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(.MEM_WORDS(MW), .BIG_ENDIAN(BE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem_arr [0:MW-1];
    int wr_cnt  = 0;
    int rsp_cnt = 0;

    assign bus.mem_Data_out = (bus.mem_Addr < MW) ? mem_arr[bus.mem_Addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_R_W) begin
            wr_cnt <= wr_cnt + 1;
            if (bus.mem_Addr < MW) mem_arr[bus.mem_Addr[9:0]] <= bus.mem_Data_in;
        end
        if (bus.resp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference memory kept as individual bytes at their byte addresses.
    logic [7:0] rb [0:RB-1];

    function automatic logic [31:0] ref_word(input int w);
        if (BE) return {rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]};
        else    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic uns);
        logic [15:0] h;
        case (sz)
            2'b00: return uns ? {24'h0, rb[a]} : {{24{rb[a][7]}}, rb[a]};
            2'b01: begin
                h = BE ? {rb[a], rb[a+1]} : {rb[a+1], rb[a]};
                return uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return ref_word(a / 4);
        endcase
    endfunction

    task automatic ref_store(input int a, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            // Most significant byte goes to the lowest address when big-endian.
            if (BE) rb[a+k] = wd[8*(n-1-k) +: 8];
            else    rb[a+k] = wd[8*k +: 8];
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output int wrs);
        bit acc;
        int wbase;
        @(negedge clk);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        wbase = wr_cnt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        rd  = 32'hxxxxxxxx;
        er  = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = n;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
                break;
            end
        end
        wrs = wr_cnt - wbase;
        @(negedge clk);
        chk("resp_pulse_len", 32'(bus.resp_valid), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic        chk_mem;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vec [20];
    logic [31:0] bb_addr [3];
    logic [31:0] bb_exp  [3];
    int acc_c [3];
    int rsp_c [3];

    initial begin
        logic [31:0] rd, exp_rd, wd;
        logic        er, exp_er, uns, we, rdy;
        logic [1:0]  sz;
        int          lat, wrs, exp_lat, a, ai, ri, rbase;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        vec[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 1'b1, 32'hDEADBEEF};
        vec[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 1'b0, 32'h0};
        vec[2]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 32'h0,        1'b0, 2, 1, 1'b1, 32'h80FF7F01};
        vec[3]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 0, 1'b0, 32'h0};
        vec[4]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0, 2, 0, 1'b0, 32'h0};
        vec[5]  = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'h0000007F, 1'b0, 2, 0, 1'b0, 32'h0};
        vec[6]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h00007F01, 1'b0, 2, 0, 1'b0, 32'h0};
        vec[7]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 2, 1, 1'b1, 32'h11223344};
        vec[8]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h1234AAAA, 32'h0,        1'b0, 3, 1, 1'b1, 32'hAAAA3344};
        vec[9]  = '{1'b1, 2'b00, 1'b0, 32'h10, 32'hFFFFFF55, 32'h0,        1'b0, 3, 1, 1'b1, 32'hAAAA3355};
        vec[10] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hAAAA3355, 1'b0, 2, 0, 1'b0, 32'h0};
        vec[11] = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0, 1'b1, 32'hAAAA3355};
        vec[12] = '{1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 1, 0, 1'b1, 32'hAAAA3355};
        vec[13] = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 1'b1, 32'hAAAA3355};
        vec[14] = '{1'b0, 2'b10, 1'b0, 4*MW,   32'h0,        32'h0,        1'b1, 1, 0, 1'b0, 32'h0};
        vec[15] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h0,        32'h0,        1'b0, 2, 1, 1'b1, 32'h0};
        vec[15] = '{1'b1, 2'b10, 1'b0, 4*MW+16, 32'h5A5A5A5A, 32'h0,      1'b1, 1, 0, 1'b1, 32'hAAAA3355};
        vec[16] = '{1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF, 32'h0,        1'b1, 1, 0, 1'b1, 32'hAAAA3355};
        vec[17] = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFFAAAA, 1'b0, 2, 0, 1'b0, 32'h0};
        vec[18] = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h0000AAAA, 1'b0, 2, 0, 1'b0, 32'h0};
        vec[19] = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'h00000033, 1'b0, 2, 0, 1'b0, 32'h0};

        // Reset values while rst is held.
        #2;
        chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
        chk("rst_mem_R_W",    32'(bus.mem_R_W),    32'd0);
        chk("rst_mem_Addr",   bus.mem_Addr,        32'd0);
        chk("rst_mem_Data_in", bus.mem_Data_in,    32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_req(vec[i].we, vec[i].sz, vec[i].uns, vec[i].addr, vec[i].wdata, rd, er, lat, wrs);
            chk($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vec[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vec[i].exp_lat));
            chk($sformatf("vec%0d_write_cycles", i), 32'(wrs), 32'(vec[i].exp_wr));
            if (vec[i].chk_mem) chk($sformatf("vec%0d_mem_word4", i), mem_arr[4], vec[i].exp_mem);
        end

        // Back-to-back loads with req_valid held high.
        bb_addr[0] = 32'h20; bb_addr[1] = 32'h24; bb_addr[2] = 32'h28;
        bb_exp[0]  = 32'h01020304; bb_exp[1] = 32'hC0FFEE00; bb_exp[2] = 32'h7EADF00D;
        for (int k = 0; k < 3; k++) do_req(1'b1, 2'b10, 1'b0, bb_addr[k], bb_exp[k], rd, er, lat, wrs);
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        bus.req_addr = bb_addr[0]; bus.req_valid = 1'b1;
        ai = 0; ri = 0;
        for (int c = 0; c < 60 && ri < 3; c++) begin
            if (bus.resp_valid) begin
                chk($sformatf("b2b_rdata%0d", ri), bus.resp_rdata, bb_exp[ri]);
                chk("b2b_ready_in_resp", 32'(bus.req_ready), 32'd0);
                rsp_c[ri] = c;
                ri++;
            end else if (ai > ri) begin
                chk("b2b_ready_in_load", 32'(bus.req_ready), 32'd0);
            end
            rdy = bus.req_ready && bus.req_valid;
            if (rdy && ai < 3) begin
                acc_c[ai] = c;
                ai++;
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                if (ai < 3) bus.req_addr = bb_addr[ai];
                else        bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("b2b_resp_count", 32'(ri), 32'd3);
        if (ri == 3) begin
            for (int k = 1; k < 3; k++)
                chk($sformatf("b2b_accept_gap%0d", k), 32'(acc_c[k] - rsp_c[k-1]), 32'd1);
        end

        // Reset asserted while the RMW write cycle is on the bus.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rd, er, lat, wrs);
        @(negedge clk);
        rbase = rsp_cnt;
        bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h99; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 chk("rmw_wr_active", 32'(bus.mem_R_W), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_mid_rmw_R_W", 32'(bus.mem_R_W), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_rmw_mem", mem_arr[4], 32'h11223344);
        chk("rst_mid_rmw_Addr", bus.mem_Addr, 32'd0);
        chk("rst_mid_rmw_Data_in", bus.mem_Data_in, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_rmw_no_resp", 32'(rsp_cnt - rbase), 32'd0);
        chk("rst_mid_rmw_ready", 32'(bus.req_ready), 32'd1);

        // Random traffic against the byte-level reference.
        for (int w = 0; w < RB / 4; w++) begin
            wd = $urandom;
            do_req(1'b1, 2'b10, 1'b0, 32'(4*w), wd, rd, er, lat, wrs);
            ref_store(4*w, 2'b10, wd);
        end
        for (int i = 0; i < 150; i++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if ($urandom_range(0, 9) == 0) a = 4*MW + $urandom_range(0, 15);
            else                           a = $urandom_range(0, RB - 1);
            exp_er = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
                     (sz == 2'b10 && a % 4 != 0) || (a / 4 >= MW);
            if (exp_er)                  exp_lat = 1;
            else if (we && sz != 2'b10)  exp_lat = 3;
            else                         exp_lat = 2;
            exp_rd = (exp_er || we) ? 32'h0 : ref_load(a, sz, uns);
            do_req(we, sz, uns, 32'(a), wd, rd, er, lat, wrs);
            if (we && !exp_er) ref_store(a, sz, wd);
            chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(exp_er));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
            chk($sformatf("rnd%0d_write_cycles", i), 32'(wrs), 32'((we && !exp_er) ? 1 : 0));
            if (a / 4 < RB / 4) chk($sformatf("rnd%0d_mem", i), mem_arr[a/4], ref_word(a / 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
